// File: rtl/snake_if.sv
// Control/status bundle between a snake_engine and its controller.
// master drives the move/grow requests; slave (the engine) drives the snake state.
interface snake_if #(
    parameter int MAX_LEN = 16,
    parameter int POS_W   = 10
) ();
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                     start;
    logic                     step;
    logic [1:0]               dir_in;
    logic                     grow;
    logic [MAX_LEN*POS_W-1:0] body;
    logic [LW-1:0]            len;
    logic                     running;
    logic                     dead;
    logic                     full;

    modport master (
        output start, step, dir_in, grow,
        input  body, len, running, dead, full
    );

    modport slave (
        input  start, step, dir_in, grow,
        output body, len, running, dead, full
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: keeps the segment list on a WIDTH x HEIGHT board and
// advances it one cell per step, detecting wall and self collisions.
module snake_engine #(
    parameter int MAX_LEN  = 16,
    parameter int POS_W    = 10,
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 24,
    parameter int INIT_LEN = 4
) (
    input logic    clk,
    input logic    rst_n,
    snake_if.slave bus
);
    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int HEAD0 = (HEIGHT / 2) * WIDTH + WIDTH / 2;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {LEFT = 2'b00, RIGHT = 2'b01, UP = 2'b10, DOWN = 2'b11} dir_t;

    state_t             state, state_nxt;
    dir_t               cur_dir, moved_dir, dir_acc;
    logic [POS_W-1:0]   seg [MAX_LEN];
    logic [LW-1:0]      len_q;
    logic               grow_pending;
    logic [POS_W-1:0]   head, next_head;
    logic               grow_eff, grow_apply, wall, self_hit, collide;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    always_comb begin
        dir_acc = cur_dir;
        if (bus.dir_in != opposite(moved_dir))
            dir_acc = dir_t'(bus.dir_in);

        head       = seg[0];
        grow_eff   = grow_pending | bus.grow;
        grow_apply = grow_eff && (len_q < LW'(MAX_LEN));

        wall      = 1'b0;
        next_head = head;
        case (dir_acc)
            LEFT: begin
                wall      = (head % POS_W'(WIDTH)) == '0;
                next_head = head - POS_W'(1);
            end
            RIGHT: begin
                wall      = (head % POS_W'(WIDTH)) == POS_W'(WIDTH - 1);
                next_head = head + POS_W'(1);
            end
            UP: begin
                wall      = head < POS_W'(WIDTH);
                next_head = head - POS_W'(WIDTH);
            end
            default: begin
                wall      = head >= POS_W'((HEIGHT - 1) * WIDTH);
                next_head = head + POS_W'(WIDTH);
            end
        endcase

        // The tail cell is vacated on a plain step, so it only blocks when growing.
        self_hit = 1'b0;
        for (int unsigned k = 1; k < MAX_LEN; k++) begin
            if (seg[k] == next_head &&
                (int'(k) < int'(len_q) - 1 || (grow_apply && int'(k) < int'(len_q))))
                self_hit = 1'b1;
        end
        collide = wall | self_hit;

        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (!bus.start && bus.step && collide) state_nxt = DEAD;
            DEAD:    if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
                seg[i] <= '1;
            len_q        <= '0;
            cur_dir      <= RIGHT;
            moved_dir    <= RIGHT;
            grow_pending <= 1'b0;
        end else if (bus.start) begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
                seg[i] <= (int'(i) < INIT_LEN) ? POS_W'(HEAD0 - int'(i)) : '1;
            len_q        <= LW'(INIT_LEN);
            cur_dir      <= RIGHT;
            moved_dir    <= RIGHT;
            grow_pending <= 1'b0;
        end else if (state == RUN) begin
            cur_dir      <= dir_acc;
            grow_pending <= grow_eff;
            if (bus.step && !collide) begin
                // Growing extends the shift by one slot so the old tail cell is kept.
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    if (int'(i) < int'(len_q) || (grow_apply && int'(i) == int'(len_q)))
                        seg[i] <= seg[i-1];
                end
                seg[0]       <= next_head;
                moved_dir    <= dir_acc;
                grow_pending <= 1'b0;
                if (grow_apply)
                    len_q <= len_q + LW'(1);
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
        assign bus.body[g*POS_W +: POS_W] = seg[g];
    end

    assign bus.len     = len_q;
    assign bus.running = (state == RUN);
    assign bus.dead    = (state == DEAD);
    assign bus.full    = (len_q == LW'(MAX_LEN));
endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed scenarios plus random traffic, all
// compared against a queue-based model of the snake after every clock.
module tb_snake_engine;
    localparam int MAX_LEN  = 16;
    localparam int POS_W    = 10;
    localparam int WIDTH    = 32;
    localparam int HEIGHT   = 24;
    localparam int INIT_LEN = 4;
    localparam int BW       = MAX_LEN * POS_W;
    localparam int HEAD0    = (HEIGHT / 2) * WIDTH + WIDTH / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_if #(.MAX_LEN(MAX_LEN), .POS_W(POS_W)) bus ();

    snake_engine #(
        .MAX_LEN (MAX_LEN),
        .POS_W   (POS_W),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .INIT_LEN(INIT_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference snake: q[0] is the head, q.size() is the length.
    int q[$];
    int m_cur, m_moved;
    bit m_pend, m_run, m_dead;
    int OPP[4] = '{1, 0, 3, 2};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [BW-1:0] exp_body();
        logic [BW-1:0] b = '1;
        for (int i = 0; i < q.size(); i++)
            b[i*POS_W +: POS_W] = POS_W'(q[i]);
        return b;
    endfunction

    function automatic int seg_at(input int i);
        return int'(bus.body[i*POS_W +: POS_W]);
    endfunction

    task automatic model_clock(input bit r, input bit s, input bit st, input bit g, input int d);
        if (!r) begin
            q.delete();
            m_cur = 1; m_moved = 1; m_pend = 0; m_run = 0; m_dead = 0;
        end else if (s) begin
            q.delete();
            for (int i = 0; i < INIT_LEN; i++)
                q.push_back(HEAD0 - i);
            m_cur = 1; m_moved = 1; m_pend = 0; m_run = 1; m_dead = 0;
        end else if (m_run) begin
            int  nd  = (d != OPP[m_moved]) ? d : m_cur;
            bit  ge  = m_pend || g;
            m_cur = nd;
            if (st) begin
                int row = q[0] / WIDTH;
                int col = q[0] % WIDTH;
                bit hit = 0;
                bit ga  = ge && (q.size() < MAX_LEN);
                int occ;
                int nh;
                case (nd)
                    0: if (col == 0)          hit = 1; else col--;
                    1: if (col == WIDTH - 1)  hit = 1; else col++;
                    2: if (row == 0)          hit = 1; else row--;
                    default: if (row == HEIGHT - 1) hit = 1; else row++;
                endcase
                nh  = row * WIDTH + col;
                occ = ga ? q.size() : q.size() - 1;
                for (int k = 1; k < occ; k++)
                    if (q[k] == nh) hit = 1;
                if (hit) begin
                    m_run = 0; m_dead = 1; m_pend = ge;
                end else begin
                    q.push_front(nh);
                    if (!ga) void'(q.pop_back());
                    m_moved = nd;
                    m_pend  = 0;
                end
            end else begin
                m_pend = ge;
            end
        end
    endtask

    task automatic compare_all();
        check("len",     256'(bus.len),     256'(q.size()));
        check("running", 256'(bus.running), 256'(m_run));
        check("dead",    256'(bus.dead),    256'(m_dead));
        check("full",    256'(bus.full),    256'(q.size() == MAX_LEN));
        check("body",    256'(bus.body),    256'(exp_body()));
    endtask

    task automatic tick(input bit r, input bit s, input bit st, input bit g, input int d);
        rst_n      = r;
        bus.start  = s;
        bus.step   = st;
        bus.grow   = g;
        bus.dir_in = d[1:0];
        @(posedge clk);
        #1;
        model_clock(r, s, st, g, d);
        compare_all();
    endtask

    initial begin
        bus.start = 0; bus.step = 0; bus.grow = 0; bus.dir_in = 2'b01;

        // Reset state
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 1, 1, 2);
        check("rst_len0",  256'(bus.len), 256'(0));
        check("rst_body1", 256'(bus.body), 256'({BW{1'b1}}));
        tick(1, 0, 1, 0, 1);

        // Start and march right
        tick(1, 1, 0, 0, 1);
        check("start_head", 256'(seg_at(0)), 256'(400));
        for (int i = 0; i < 8; i++) tick(1, 0, 1, 0, 1);
        check("head_408", 256'(seg_at(0)), 256'(408));
        check("seg3_405", 256'(seg_at(3)), 256'(405));

        // Reversal ignored, then turn up
        tick(1, 1, 0, 0, 1);
        tick(1, 0, 1, 0, 0);
        check("rev_401", 256'(seg_at(0)), 256'(401));
        tick(1, 0, 1, 0, 2);
        check("up_369", 256'(seg_at(0)), 256'(369));

        // Right wall
        tick(1, 1, 0, 0, 1);
        for (int i = 0; i < 15; i++) tick(1, 0, 1, 0, 1);
        check("col31", 256'(seg_at(0)), 256'(415));
        tick(1, 0, 1, 0, 1);
        check("wall_dead", 256'(bus.dead), 256'(1));
        check("wall_head", 256'(seg_at(0)), 256'(415));
        tick(1, 0, 1, 1, 2);
        tick(1, 0, 1, 0, 3);
        check("dead_hold", 256'(seg_at(0)), 256'(415));
        tick(1, 1, 1, 1, 1);
        check("restart_head", 256'(seg_at(0)), 256'(400));

        // Growth up to full, then saturation
        tick(1, 0, 1, 1, 1);
        check("grow_len5", 256'(bus.len), 256'(5));
        check("grow_tail", 256'(seg_at(4)), 256'(397));
        for (int i = 0; i < 11; i++) tick(1, 0, 1, 1, 1);
        check("len16", 256'(bus.len), 256'(16));
        check("full1", 256'(bus.full), 256'(1));
        tick(1, 0, 1, 1, 1);
        check("len_sat", 256'(bus.len), 256'(16));

        // Tight loop collisions: length 5 dies, length 4 chases its tail
        tick(1, 1, 0, 0, 1);
        tick(1, 0, 1, 1, 1);
        tick(1, 0, 1, 0, 3);
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 2);
        check("loop5_dead", 256'(bus.dead), 256'(1));
        tick(1, 1, 0, 0, 1);
        tick(1, 0, 1, 0, 1);
        tick(1, 0, 1, 0, 3);
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 2);
        check("loop4_run",  256'(bus.running), 256'(1));
        check("loop4_head", 256'(seg_at(0)), 256'(400));

        // Reset coincident with step and grow mid-run
        tick(1, 0, 0, 1, 3);
        tick(0, 0, 1, 1, 3);
        check("rst_mid_len",  256'(bus.len), 256'(0));
        check("rst_mid_body", 256'(bus.body), 256'({BW{1'b1}}));
        tick(1, 0, 1, 0, 1);
        check("rst_mid_idle", 256'(bus.running), 256'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r  = ($urandom_range(0, 299) != 0);
            bit s  = ($urandom_range(0, 39) == 0);
            bit st = ($urandom_range(0, 1) == 1);
            bit g  = ($urandom_range(0, 3) == 0);
            int d  = int'($urandom_range(0, 3));
            tick(r, s, st, g, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
